// File: rtl/vga_pkg.sv
// Shared VGA-domain definitions: screen and sprite geometry, the animator
// state type and a saturating velocity helper used by per-frame animators.
package vga_pkg;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 64;

  // Largest legal sprite top-left coordinates that keep the sprite on screen.
  localparam logic [11:0] GROUND_Y_DEF = 12'(SCREEN_H - SPRITE_H);
  localparam logic [11:0] X_MAX_DEF    = 12'(SCREEN_W - SPRITE_W);

  typedef enum logic [1:0] {IDLE, FLIGHT, LANDED} state_t;

  // Adds an acceleration to a velocity, clamping to [-128, vmax].
  function automatic logic signed [7:0] sat_add_vel(
    input logic signed [7:0] vel,
    input logic signed [7:0] acc,
    input logic signed [7:0] vmax
  );
    logic signed [8:0] sum;
    sum = vel + acc;
    if (sum > vmax) begin
      return vmax;
    end else if (sum < -9'sd128) begin
      return -8'sd128;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Vertical-blanking rising-edge detector: one tick per video frame.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic r_vblnk_d;

  // Delay vblnk by one cycle so its rising edge can be detected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d <= 1'b0;
    end else begin
      r_vblnk_d <= vblnk;
    end
  end

  assign tick = vblnk & ~r_vblnk_d;

endmodule

// File: rtl/projectile_ctl.sv
// Per-frame motion controller for a thrown sprite: horizontal velocity,
// gravity on the vertical velocity, wall/ceiling clamps and ground landing.
// Position only advances on the frame tick so the sprite never tears.
module projectile_ctl
  import vga_pkg::*;
#(
  parameter logic        [11:0] HOME_X      = 12'd64,
  parameter logic        [11:0] GROUND_Y    = GROUND_Y_DEF,
  parameter logic        [11:0] X_MAX       = X_MAX_DEF,
  parameter logic signed [7:0]  GRAVITY     = 8'sd1,
  parameter logic signed [7:0]  VY_MAX      = 8'sd127,
  parameter logic        [7:0]  LAND_FRAMES = 8'd30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblnk,
  input  logic              throw,
  input  logic [11:0]       start_x,
  input  logic [11:0]       start_y,
  input  logic signed [7:0] vel_x,
  input  logic signed [7:0] vel_y,
  output logic [11:0]       xpos,
  output logic [11:0]       ypos,
  output logic              busy,
  output logic              landed
);

  state_t             r_state;
  state_t             w_state_next;
  logic [11:0]        r_xpos, w_xpos_next;
  logic [11:0]        r_ypos, w_ypos_next;
  logic signed [7:0]  r_vx, w_vx_next;
  logic signed [7:0]  r_vy, w_vy_next;
  logic [7:0]         r_cnt, w_cnt_next;
  logic               r_busy, w_busy_next;
  logic               r_landed, w_landed_next;

  logic               w_tick;
  logic signed [12:0] w_x_sum;
  logic signed [12:0] w_y_sum;
  logic               w_x_under, w_x_over;
  logic               w_y_under, w_y_ground;
  logic               w_touchdown;
  logic [7:0]         w_cnt_inc;
  logic               w_land_done;

  frame_tick_gen u_tick (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .tick  (w_tick)
  );

  // Candidate positions in 13-bit signed arithmetic so under/overflow is visible.
  assign w_x_sum    = $signed({1'b0, r_xpos}) + $signed({{5{r_vx[7]}}, r_vx});
  assign w_y_sum    = $signed({1'b0, r_ypos}) + $signed({{5{r_vy[7]}}, r_vy});
  assign w_x_under  = (w_x_sum < 13'sd0);
  assign w_x_over   = (w_x_sum > $signed({1'b0, X_MAX}));
  assign w_y_under  = (w_y_sum < 13'sd0);
  // Ground only counts while falling, so a ground-level launch does not land at once.
  assign w_y_ground = (r_vy > 8'sd0) && (w_y_sum >= $signed({1'b0, GROUND_Y}));
  assign w_touchdown = (r_state == FLIGHT) && w_tick && !w_y_under && w_y_ground;
  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_land_done = (r_state == LANDED) && w_tick && (w_cnt_inc == LAND_FRAMES);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; throws outside IDLE are dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (throw)       w_state_next = FLIGHT;
      FLIGHT:  if (w_touchdown) w_state_next = LANDED;
      LANDED:  if (w_land_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath next values: launch latch, physics step and landing hold counter.
  always_comb begin
    logic signed [7:0] vy_base;
    w_xpos_next   = r_xpos;
    w_ypos_next   = r_ypos;
    w_vx_next     = r_vx;
    w_vy_next     = r_vy;
    w_cnt_next    = r_cnt;
    w_landed_next = 1'b0;
    vy_base       = r_vy;
    case (r_state)
      IDLE: begin
        if (throw) begin
          w_xpos_next = start_x;
          w_ypos_next = start_y;
          w_vx_next   = vel_x;
          w_vy_next   = vel_y;
        end
      end
      FLIGHT: begin
        if (w_tick) begin
          if (w_x_under) begin
            w_xpos_next = 12'd0;
            w_vx_next   = 8'sd0;
          end else if (w_x_over) begin
            w_xpos_next = X_MAX;
            w_vx_next   = 8'sd0;
          end else begin
            w_xpos_next = w_x_sum[11:0];
          end

          if (w_y_under) begin
            w_ypos_next = 12'd0;
            vy_base     = 8'sd0;
          end else if (w_y_ground) begin
            w_ypos_next   = GROUND_Y;
            w_vx_next     = 8'sd0;
            vy_base       = 8'sd0;
            w_landed_next = 1'b1;
            w_cnt_next    = 8'd0;
          end else begin
            w_ypos_next = w_y_sum[11:0];
          end

          if (w_touchdown) begin
            w_vy_next = 8'sd0;
          end else begin
            w_vy_next = sat_add_vel(vy_base, GRAVITY, VY_MAX);
          end
        end
      end
      LANDED: begin
        if (w_tick) begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: ;
    endcase
    w_busy_next = (w_state_next != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xpos   <= HOME_X;
      r_ypos   <= GROUND_Y;
      r_vx     <= 8'sd0;
      r_vy     <= 8'sd0;
      r_cnt    <= 8'd0;
      r_busy   <= 1'b0;
      r_landed <= 1'b0;
    end else begin
      r_xpos   <= w_xpos_next;
      r_ypos   <= w_ypos_next;
      r_vx     <= w_vx_next;
      r_vy     <= w_vy_next;
      r_cnt    <= w_cnt_next;
      r_busy   <= w_busy_next;
      r_landed <= w_landed_next;
    end
  end

  assign xpos   = r_xpos;
  assign ypos   = r_ypos;
  assign busy   = r_busy;
  assign landed = r_landed;

endmodule

// File: doc/projectile_ctl.md
Name: projectile_ctl

Overview:
- Per-frame motion controller for one thrown sprite: a projectile with a horizontal velocity and gravity on the vertical velocity.
- Produces the sprite's top-left xpos/ypos for the rectangle/sprite drawing stage directly downstream; that stage consumes them as its position inputs.
- Updates only once per frame, at the rising edge of vertical blanking, so the drawn sprite never tears mid-frame.

Parameters:
- HOME_X, 12'd64, xpos value at reset and while idle before the first throw
- GROUND_Y, 12'd536, ground line for the sprite top (600 - 64)
- X_MAX, 12'd736, largest legal xpos (800 - 64)
- GRAVITY, 8'sd1, added to vy every frame tick, in px/frame
- VY_MAX, 8'sd127, saturation limit for vy
- LAND_FRAMES, 8'd30, number of frame ticks held in LANDED

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vblnk  in  1  vertical blanking from the timing interface
- throw  in  1  single-cycle launch request
- start_x  in  12  launch x, sampled when a throw is accepted
- start_y  in  12  launch y, sampled when a throw is accepted
- vel_x  in  8 (signed)  launch horizontal velocity, px/frame
- vel_y  in  8 (signed)  launch vertical velocity, px/frame; negative means up
- xpos  out  12  sprite x, registered
- ypos  out  12  sprite y, registered
- busy  out  1  high in FLIGHT and LANDED
- landed  out  1  one-cycle pulse on touchdown

Behaviour:
- Reset is synchronous on clk, active-high.
- Reset values: xpos = HOME_X, ypos = GROUND_Y, busy = 0, landed = 0, state = IDLE, vx = vy = 0, vblnk_d = 0, frame counter = 0.
- Reset asserted mid-flight aborts to these values on the next edge.
- Frame tick: tick = vblnk & ~vblnk_d, with vblnk_d registered each cycle. Exactly one tick per frame.
- All outputs are registered. Any update triggered by tick or throw is visible the cycle after that edge.
- States: IDLE, FLIGHT, LANDED.
- IDLE:
  - throw = 1 latches vx = vel_x, vy = vel_y, xpos = start_x, ypos = start_y, and moves to FLIGHT.
  - This happens regardless of tick; if tick is high in the same cycle, throw wins and no physics step is applied that cycle.
- FLIGHT, on each tick, in this order, using 13-bit signed arithmetic:
  - x_n = xpos + vx.
    - If x_n < 0: xpos = 0, vx = 0.
    - If x_n > X_MAX: xpos = X_MAX, vx = 0.
    - Otherwise xpos = x_n.
  - y_n = ypos + vy.
    - If y_n < 0: ypos = 0, vy = 0.
    - Else if vy > 0 and y_n >= GROUND_Y: ypos = GROUND_Y, vx = vy = 0, landed pulses, go to LANDED.
    - Otherwise ypos = y_n.
  - If not landed: vy = min(vy + GRAVITY, VY_MAX), saturating.
  - Ground detection applies only when vy > 0, so a launch from ground level with vy <= 0 does not land immediately.
- LANDED:
  - Counter clears on entry and increments per tick.
  - When the counter reaches LAND_FRAMES, go to IDLE and drop busy.
  - xpos/ypos hold their landed values.
- throw is ignored in FLIGHT and LANDED; there is no queuing.
- Between ticks, xpos/ypos are stable.

Decomposition:
- Shared vga_pkg gets: the state typedef (enum logic [1:0] {IDLE, FLIGHT, LANDED}), SPRITE_W/SPRITE_H = 64, and the screen width/height constants that GROUND_Y and X_MAX derive from.
- One natural sub-module: frame_tick_gen (vblnk rising-edge detector). Reused by other per-frame animators.

Test Plan:
- Reset during FLIGHT (ypos = 500) -> next cycle xpos = 64, ypos = 536, busy = 0, landed = 0.
- Throw start (100, 536), vel (4, -10), GRAVITY = 1:
  - after tick 1 -> (104, 526).
  - after tick 10 -> ypos = 481.
  - tick 21 -> (184, 536), landed pulses for exactly 1 cycle.
  - busy falls at tick 51.
- Throw start (730, 300), vel (10, 0) -> tick 1 gives xpos = 736 with vx frozen; ypos keeps falling until it clamps to 536.
- Throw start (200, 20), vel (0, -30) -> tick 1 gives ypos = 0, vy = 0 then +1; subsequent ticks ypos = 0, 1, 3, ...
- throw asserted in the same cycle as tick -> position equals start values (no step applied); second throw during FLIGHT ignored, trajectory unchanged.
- Hold vblnk high for 1000 cycles -> exactly one step applied; xpos/ypos never change while vblnk is low.
